// File: rtl/mips_shift_pkg.sv
// ============================================================================
// Module      : mips_shift_pkg
// Description : Shared encodings for the multi-cycle MIPS shift unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_ROTR = 2'b11
    } sh_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sh_state_e;

endpackage : mips_shift_pkg

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational shift of a WIDTH-bit word by 0..STEP bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
    import mips_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    parameter int unsigned KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [KW-1:0]    i_k,
    input  sh_mode_e         i_mode,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sra_fill;
    logic [31:0]      w_lsh;

    assign w_srl      = i_data >> i_k;
    // Ones exactly where SRL introduced zeros; gated by the latched sign.
    assign w_sra_fill = ~({WIDTH{1'b1}} >> i_k) & {WIDTH{i_sign}};
    // A left shift by WIDTH (k == 0) yields zero, so rotate-by-0 is a no-op.
    assign w_lsh      = WIDTH - 32'(i_k);

    always_comb begin
        o_data = i_data;
        unique case (i_mode)
            SH_SLL:  o_data = i_data << i_k;
            SH_SRL:  o_data = w_srl;
            SH_SRA:  o_data = w_srl | w_sra_fill;
            SH_ROTR: o_data = w_srl | (i_data << w_lsh);
            default: o_data = i_data;
        endcase
    end

endmodule : shift_step

`default_nettype wire

// File: rtl/shift_unit_mc.sv
// ============================================================================
// Module      : shift_unit_mc
// Description : Multi-cycle SLL/SRL/SRA/ROTR unit, STEP bits per cycle, with
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_mc
    import mips_shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned STEP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_in,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [1:0]         i_mode,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WIDTH-1:0]   o_out,
    output logic               o_busy
);

    localparam int unsigned KW = $clog2(STEP + 1);
    // Common width able to hold both rem and STEP for the min() compare.
    localparam int unsigned CW = ((SHAMT_W > KW) ? SHAMT_W : KW) + 1;

    sh_state_e          r_state;
    sh_state_e          w_state_nxt;
    logic [WIDTH-1:0]   r_out;
    logic [SHAMT_W-1:0] r_rem;
    sh_mode_e           r_mode;
    logic               r_sign;

    logic [CW-1:0]      w_rem_ext;
    logic [CW-1:0]      w_step_ext;
    logic [CW-1:0]      w_k_ext;
    logic [KW-1:0]      w_k;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH-1:0]   w_shifted;

    assign w_rem_ext  = CW'(r_rem);
    assign w_step_ext = CW'(STEP);
    assign w_k_ext    = (w_rem_ext > w_step_ext) ? w_step_ext : w_rem_ext;
    assign w_k        = KW'(w_k_ext);
    assign w_last     = (w_k_ext == w_rem_ext);
    assign w_accept   = (r_state == ST_IDLE) && i_in_valid;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_shift_step (
        .i_data (r_out),
        .i_k    (w_k),
        .i_mode (r_mode),
        .i_sign (r_sign),
        .o_data (w_shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_in_valid) begin
                    w_state_nxt = (i_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_rem  <= '0;
            r_mode <= SH_SLL;
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_out  <= i_in;
            r_rem  <= i_shamt;
            r_mode <= sh_mode_e'(i_mode);
            r_sign <= i_in[WIDTH-1];
        end else if (r_state == ST_SHIFT) begin
            r_out  <= w_shifted;
            r_rem  <= r_rem - SHAMT_W'(w_k_ext);
        end
    end

    // Handshake flags come from registered state only.
    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_out       = r_out;

endmodule : shift_unit_mc

`default_nettype wire

// File: tb/tb_shift_unit_mc.sv
// ============================================================================
// Module      : tb_shift_unit_mc
// Description : Directed + randomised scoreboard bench for shift_unit_mc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_unit_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  busy;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic [31:0] dout [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    shift_unit_mc #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_in(din), .i_shamt(shamt), .i_mode(mode), .o_out_valid(out_valid[0]),
        .i_out_ready(out_ready[0]), .o_out(dout[0]), .o_busy(busy[0]));

    shift_unit_mc #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_in(din), .i_shamt(shamt), .i_mode(mode), .o_out_valid(out_valid[1]),
        .i_out_ready(out_ready[1]), .o_out(dout[1]), .o_busy(busy[1]));

    shift_unit_mc #(.WIDTH(32), .STEP(32)) u_s32 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
        .i_in(din), .i_shamt(shamt), .i_mode(mode), .o_out_valid(out_valid[2]),
        .i_out_ready(out_ready[2]), .o_out(dout[2]), .o_busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int step_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 4 : 32);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] m, input logic [4:0] s,
                                          input logic [31:0] d);
        logic signed [31:0] sd;
        logic [31:0]        r;
        sd = d;
        r  = d;
        case (m)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = sd >>> s;
            default: for (int i = 0; i < int'(s); i++) r = {r[0], r[31:1]};
        endcase
        return r;
    endfunction

    // Latency counted in rising edges from the edge after which the request
    // is presented until the first edge after which OUT_VALID is high.
    task automatic run_op(input int idx, input logic [1:0] m, input logic [4:0] s,
                          input logic [31:0] d, input int hold);
        exp_t        e;
        int          cyc;
        logic        got;
        logic [31:0] held;
        e.data = model(m, s, d);
        e.lat  = 1 + (int'(s) + step_of(idx) - 1) / step_of(idx);
        sb.push_back(e);
        @(posedge clk); #1;
        check("in_ready_idle", 32'(in_ready[idx]), 32'd1);
        din = d; shamt = s; mode = m; in_valid[idx] = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            in_valid[idx] = 1'b0;
            if (out_valid[idx]) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) begin
            check("timeout", 32'(got), 32'd1);
        end else begin
            check("result", dout[idx], e.data);
            check("latency", 32'(cyc), 32'(e.lat));
            held = dout[idx];
            for (int i = 0; i < hold; i++) begin
                if (i == 2) begin
                    din = ~d; shamt = 5'd3; in_valid[idx] = 1'b1;
                end
                @(posedge clk); #1;
                in_valid[idx] = 1'b0;
                check("hold_out", dout[idx], held);
                check("hold_valid", 32'(out_valid[idx]), 32'd1);
                check("hold_in_ready", 32'(in_ready[idx]), 32'd0);
            end
            out_ready[idx] = 1'b1;
            @(posedge clk); #1;
            out_ready[idx] = 1'b0;
            check("idle_in_ready", 32'(in_ready[idx]), 32'd1);
            check("idle_busy", 32'(busy[idx]), 32'd0);
            check("idle_valid", 32'(out_valid[idx]), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; out_ready = '0;
        din = '0; shamt = '0; mode = '0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst_out", dout[i], 32'h0);
            check("rst_valid", 32'(out_valid[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_in_ready", 32'(in_ready[i]), 32'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(1, 2'b00, 5'd2,  32'h0000_0001, 0);
        run_op(1, 2'b01, 5'd5,  32'hF000_0000, 0);
        run_op(1, 2'b10, 5'd31, 32'h8000_0000, 0);
        run_op(1, 2'b11, 5'd4,  32'h0000_00F1, 0);
        run_op(1, 2'b01, 5'd0,  32'hDEAD_BEEF, 5);

        // Abort SRA by 20 during its second SHIFT cycle.
        @(posedge clk); #1;
        din = 32'h8765_4321; shamt = 5'd20; mode = 2'b10; in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("pre_abort_busy", 32'(busy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out", dout[1], 32'h0);
        check("abort_valid", 32'(out_valid[1]), 32'd0);
        check("abort_busy", 32'(busy[1]), 32'd0);
        check("abort_in_ready", 32'(in_ready[1]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(1, 2'b00, 5'd31, 32'h0000_0001, 0);

        run_op(2, 2'b10, 5'd31, 32'h8000_0000, 0);
        run_op(2, 2'b11, 5'd0,  32'h1234_5678, 0);
        run_op(0, 2'b11, 5'd31, 32'h8000_0001, 0);

        for (int n = 0; n < 45; n++) begin
            run_op(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 31)), $urandom, 0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_unit_mc

`default_nettype wire
